// File: rtl/adpcm_filtez_mac.sv
// adpcm_filtez_mac: sequential multiply-accumulate controller for the ADPCM
// zero-predictor filter. Streams TAPS coefficient/difference pairs from two
// single-port memories into an external combinational multiplier, sums the
// signed products and returns the sum arithmetically shifted right by SHIFT.
module adpcm_filtez_mac #(
  parameter int TAPS  = 6,
  parameter int AW    = 3,
  parameter int DW    = 14,
  parameter int PW    = 28,
  parameter int ACC_W = 32,
  parameter int SHIFT = 14
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic [ACC_W-1:0] ap_return,
  output logic [AW-1:0]    coef_address0,
  output logic             coef_ce0,
  input  logic [DW-1:0]    coef_q0,
  output logic [AW-1:0]    dlt_address0,
  output logic             dlt_ce0,
  input  logic [DW-1:0]    dlt_q0,
  output logic [DW-1:0]    mul_din0,
  output logic [DW-1:0]    mul_din1,
  input  logic [PW-1:0]    mul_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(TAPS - 1);

  logic [1:0]              state;
  logic [AW-1:0]           addr;
  logic                    ce;
  logic                    done_r;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0]        ret_r;

  // Operands go straight from the memory read ports to the multiplier.
  assign mul_din0 = coef_q0;
  assign mul_din1 = dlt_q0;

  assign prod_ext = {{(ACC_W - PW){mul_dout[PW-1]}}, mul_dout};

  // Both memories are walked in lockstep with a single shared address.
  assign coef_address0 = addr;
  assign dlt_address0  = addr;
  assign coef_ce0      = ce;
  assign dlt_ce0       = ce;

  assign ap_done   = done_r;
  assign ap_ready  = done_r;
  assign ap_return = ret_r;
  assign ap_idle   = (state == S_IDLE);

  // Control FSM, address generation and accumulation.
  // The issued address doubles as the tap index: while in RUN, a nonzero
  // address means the product of address-1 is on mul_dout this cycle.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      ce     <= 1'b0;
      done_r <= 1'b0;
      acc    <= '0;
      ret_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            acc   <= '0;
            addr  <= '0;
            ce    <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (addr != '0) acc <= acc + prod_ext;
          if (addr == LAST_ADDR) begin
            ce    <= 1'b0;
            addr  <= '0;
            state <= S_LAST;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        S_LAST: begin
          acc    <= acc + prod_ext;
          done_r <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          ret_r <= acc >>> SHIFT;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adpcm_filtez_mac.sv
// Directed testbench for adpcm_filtez_mac with a registered-read ROM model
// and a behavioural 14s x 14s multiplier.
module tb_adpcm_filtez_mac;

  localparam int TAPS = 6;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [31:0] ap_return;
  logic [2:0]  coef_address0;
  logic        coef_ce0;
  logic [13:0] coef_q0;
  logic [2:0]  dlt_address0;
  logic        dlt_ce0;
  logic [13:0] dlt_q0;
  logic [13:0] mul_din0;
  logic [13:0] mul_din1;
  logic [27:0] mul_dout;

  logic signed [13:0] coef_mem [0:7];
  logic signed [13:0] dlt_mem  [0:7];
  logic signed [27:0] ea, eb;

  int compared   = 0;
  int mismatched = 0;

  adpcm_filtez_mac #(
    .TAPS(TAPS), .AW(3), .DW(14), .PW(28), .ACC_W(32), .SHIFT(14)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .ap_return(ap_return),
    .coef_address0(coef_address0), .coef_ce0(coef_ce0), .coef_q0(coef_q0),
    .dlt_address0(dlt_address0), .dlt_ce0(dlt_ce0), .dlt_q0(dlt_q0),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout)
  );

  always #5 ap_clk = ~ap_clk;

  // Memories: data valid one cycle after ce0.
  always @(posedge ap_clk) begin
    if (coef_ce0) coef_q0 <= coef_mem[coef_address0];
    if (dlt_ce0)  dlt_q0  <= dlt_mem[dlt_address0];
  end

  // Combinational signed multiplier.
  assign ea = {{14{mul_din0[13]}}, mul_din0};
  assign eb = {{14{mul_din1[13]}}, mul_din1};
  assign mul_dout = ea * eb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int c, input int d);
    for (int i = 0; i < 8; i++) begin
      coef_mem[i] = 14'(c);
      dlt_mem[i]  = 14'(d);
    end
  endtask

  task automatic load_floor();
    fill(0, 0);
    coef_mem[0] = -14'sd1;
    dlt_mem[0]  = 14'sd1;
  endtask

  // One call with a start pulse; checks per-cycle handshake and addresses,
  // then the returned value. Entered and left #1 after a rising edge in IDLE.
  task automatic run_call(input string tag, input logic [31:0] exp_ret);
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int c = 1; c <= TAPS + 2; c++) begin
      chk($sformatf("%s idle c%0d", tag, c), 32'(ap_idle), 32'd0);
      chk($sformatf("%s done c%0d", tag, c), 32'(ap_done), 32'(c == TAPS + 2));
      chk($sformatf("%s ready c%0d", tag, c), 32'(ap_ready), 32'(c == TAPS + 2));
      chk($sformatf("%s ce c%0d", tag, c), 32'({coef_ce0, dlt_ce0}),
          (c <= TAPS) ? 32'd3 : 32'd0);
      if (c <= TAPS) begin
        chk($sformatf("%s caddr c%0d", tag, c), 32'(coef_address0), 32'(c - 1));
        chk($sformatf("%s daddr c%0d", tag, c), 32'(dlt_address0), 32'(c - 1));
      end
      @(posedge ap_clk); #1;
    end
    chk($sformatf("%s idle after", tag), 32'(ap_idle), 32'd1);
    chk($sformatf("%s done after", tag), 32'(ap_done), 32'd0);
    chk($sformatf("%s return", tag), ap_return, exp_ret);
  endtask

  int done_at [3];
  int ndone;
  int idle_between;
  int spurious;
  logic [31:0] held_exp [3];

  initial begin
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    fill(0, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("reset idle",   32'(ap_idle), 32'd1);
    chk("reset done",   32'(ap_done), 32'd0);
    chk("reset ready",  32'(ap_ready), 32'd0);
    chk("reset ce",     32'({coef_ce0, dlt_ce0}), 32'd0);
    chk("reset addr",   32'({coef_address0, dlt_address0}), 32'd0);
    chk("reset return", ap_return, 32'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // 6 * 1 = 6, 6 >>> 14 = 0
    fill(1, 1);
    run_call("ones", 32'd0);

    // 6 * 67108864 = 402653184, >>> 14 = 24576
    fill(-8192, -8192);
    run_call("maxneg", 32'd24576);

    // -1 >>> 14 = -1 (floor), not 0
    load_floor();
    run_call("floor", 32'hFFFF_FFFF);

    // 100000 - 200000 - 300000 + 0 + 67092481 - 67100672 = -408191
    // floor(-408191 / 16384) = floor(-24.91) = -25
    coef_mem[0] = 14'sd100;   dlt_mem[0] = 14'sd1000;
    coef_mem[1] = -14'sd200;  dlt_mem[1] = 14'sd1000;
    coef_mem[2] = 14'sd300;   dlt_mem[2] = -14'sd1000;
    coef_mem[3] = 14'sd0;     dlt_mem[3] = 14'sd5;
    coef_mem[4] = 14'sd8191;  dlt_mem[4] = 14'sd8191;
    coef_mem[5] = -14'sd8192; dlt_mem[5] = 14'sd8191;
    run_call("mixed", 32'hFFFF_FFE7);

    // ap_start held for three calls; data swapped at each done so every
    // return differs from the previous one.
    held_exp[0] = 32'hFFFF_FFFF;
    held_exp[1] = 32'd24576;
    held_exp[2] = 32'd0;
    load_floor();
    ndone = 0;
    idle_between = 0;
    ap_start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge ap_clk); #1;
      if (ndone > 0 && ndone < 3 && ap_idle) idle_between++;
      if (ap_done) begin
        if (ndone < 3) done_at[ndone] = c;
        ndone++;
        if (ndone == 1) fill(-8192, -8192);
        if (ndone == 2) fill(1, 1);
        if (ndone == 3) ap_start = 1'b0;
        @(posedge ap_clk); #1;
        c++;
        if (ndone <= 3)
          chk($sformatf("held return %0d", ndone), ap_return, held_exp[ndone-1]);
        if (ndone > 0 && ndone < 3 && ap_idle) idle_between++;
      end
    end
    ap_start = 1'b0;
    chk("held done count", 32'(ndone), 32'd3);
    chk("held first done", 32'(done_at[0]), 32'd8);
    chk("held spacing 1",  32'(done_at[1] - done_at[0]), 32'd9);
    chk("held spacing 2",  32'(done_at[2] - done_at[1]), 32'd9);
    chk("held idle gaps",  32'(idle_between), 32'd2);
    chk("held end idle",   32'(ap_idle), 32'd1);

    // Nonzero return so the reset clearing it is observable.
    fill(-8192, -8192);
    run_call("pre-reset", 32'd24576);

    // Reset asserted during cycle 3 of a call.
    fill(1, 1);
    ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    chk("abort idle",   32'(ap_idle), 32'd1);
    chk("abort ce",     32'({coef_ce0, dlt_ce0}), 32'd0);
    chk("abort addr",   32'({coef_address0, dlt_address0}), 32'd0);
    chk("abort return", ap_return, 32'd0);
    chk("abort done",   32'(ap_done), 32'd0);
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge ap_clk); #1;
      if (ap_done || !ap_idle) spurious++;
    end
    chk("abort no done", 32'(spurious), 32'd0);

    run_call("post-abort", 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
